// File: rtl/rr_arb16_idx.sv
// 16-requester round-robin arbiter with a registered 4-bit grant index and valid.
// A grant is held until done, the owner's request drops, or an optional hold timeout.
module rr_arb16_idx #(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  gnt_idx,
    output logic        gnt_vld,
    output logic        timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic        timeout_q, timeout_d;

    logic [31:0] req_dbl;
    logic [15:0] req_rot;
    logic [3:0]  win_off;
    logic [3:0]  winner;
    logic        owner_req;
    logic        expire;
    logic        release_gnt;

    // Rotate so bit 0 is the requester at ptr; the lowest set bit is the winner offset.
    always_comb begin
        req_dbl = {req, req};
        req_rot = req_dbl[ptr_q +: 16];
        win_off = '0;
        for (int k = 15; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = 4'(k);
            end
        end
        winner = ptr_q + win_off;
    end

    assign owner_req   = req[idx_q];
    assign expire      = (MAX_HOLD != 0) && (hold_q == HoldLast);
    assign release_gnt = done || !owner_req || expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en && (|req)) state_d = StGrant;
            StGrant: if (release_gnt)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en && (|req)) begin
                    idx_d  = winner;
                    hold_d = '0;
                end
            end
            StGrant: begin
                if (release_gnt) begin
                    ptr_d     = idx_q + 4'd1;
                    // Only flag a timeout when expiry is the sole release cause.
                    timeout_d = expire && owner_req && !done;
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_idx = idx_q;
    assign gnt_vld = (state_q == StGrant);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb16_idx.sv
// Bench for rr_arb16_idx: two instances (unlimited hold and MAX_HOLD=4) driven in
// lockstep and compared every cycle against a behavioural grant model.
module tb_rr_arb16_idx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        done = 1'b0;
    logic [15:0] req = '0;
    logic [3:0]  idx0, idx1;
    logic        vld0, vld1, to0, to1;

    int checks = 0;
    int errors = 0;

    int m_hold[2] = '{0, 4};
    bit m_vld[2];
    int m_idx[2];
    int m_ptr[2];
    int m_age[2];
    bit m_to[2];

    always #5 clk = ~clk;

    rr_arb16_idx #(.MAX_HOLD(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt_idx(idx0), .gnt_vld(vld0), .timeout(to0)
    );

    rr_arb16_idx #(.MAX_HOLD(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt_idx(idx1), .gnt_vld(vld1), .timeout(to1)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_vld[i] = 0;
            m_idx[i] = 0;
            m_ptr[i] = 0;
            m_age[i] = 0;
            m_to[i]  = 0;
        end
    endtask

    // One clock edge of the arbiter: age counts completed cycles of the current grant.
    task automatic model_step();
        bit d, drop, expd;
        for (int i = 0; i < 2; i++) begin
            if (!m_vld[i]) begin
                m_to[i] = 0;
                if (en && req != 16'h0) begin
                    for (int k = 15; k >= 0; k--) begin
                        if (req[(m_ptr[i] + k) % 16]) m_idx[i] = (m_ptr[i] + k) % 16;
                    end
                    m_vld[i] = 1;
                    m_age[i] = 0;
                end
            end else begin
                d    = done;
                drop = !req[m_idx[i]];
                expd = (m_hold[i] != 0) && (m_age[i] + 1 == m_hold[i]);
                if (d || drop || expd) begin
                    m_vld[i] = 0;
                    m_ptr[i] = (m_idx[i] + 1) % 16;
                    m_to[i]  = expd && !d && !drop;
                end else begin
                    m_age[i] = m_age[i] + 1;
                    m_to[i]  = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("vld0", 32'(vld0), 32'(m_vld[0]));
        check("idx0", 32'(idx0), 32'(m_idx[0]));
        check("to0",  32'(to0),  32'(m_to[0]));
        check("vld1", 32'(vld1), 32'(m_vld[1]));
        check("idx1", 32'(idx1), 32'(m_idx[1]));
        check("to1",  32'(to1),  32'(m_to[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-grant, then ptr restarts at 0
        req = 16'h0020; en = 1'b1;
        tick();
        check("t1_idx", 32'(idx0), 32'd5);
        tick();
        async_reset();
        check("t1_rst_vld", 32'(vld0), 32'd0);
        check("t1_rst_idx", 32'(idx0), 32'd0);
        tick();
        check("t1_regrant", 32'(idx0), 32'd5);
        req = 16'h0;
        tick();
        async_reset();

        // Full rotation with a single-cycle gap between grants
        req = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            tick();
            check("t2_idx", 32'(idx0), 32'(k % 16));
            check("t2_vld", 32'(vld0), 32'd1);
            done = 1'b1;
            tick();
            check("t2_gap", 32'(vld0), 32'd0);
            done = 1'b0;
        end

        // Move ptr to 14, then wrap/skip over a sparse request set
        req = 16'h2000;
        tick();
        req = 16'h0;
        tick();
        req = 16'h0009;
        tick();
        check("t3_first", 32'(idx0), 32'd0);
        done = 1'b1; tick(); done = 1'b0;
        tick();
        check("t3_second", 32'(idx0), 32'd3);
        done = 1'b1; tick(); done = 1'b0;
        tick();
        check("t3_third", 32'(idx0), 32'd0);
        req = 16'h0;
        tick();

        // Release by request drop; nothing granted while en=0
        req = 16'h0080;
        tick();
        check("t4_idx", 32'(idx0), 32'd7);
        req = 16'h0;
        tick();
        check("t4_vld", 32'(vld0), 32'd0);
        check("t4_to", 32'(to0), 32'd0);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req  = req ^ 16'h0080;
            done = ~done;
            tick();
            check("t4_idle", 32'(vld0 | vld1), 32'd0);
        end
        done = 1'b0; req = 16'h0;

        // Hold timeout on the MAX_HOLD=4 instance
        en = 1'b1; req = 16'h0100;
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vld1) hi++;
            else break;
        end
        check("t5_hold", 32'(hi), 32'd4);
        check("t5_pulse", 32'(to1), 32'd1);
        tick();
        check("t5_pulse_end", 32'(to1), 32'd0);
        check("t5_regrant", 32'(vld1), 32'd1);
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        check("t5_done_exp_to", 32'(to1), 32'd0);
        check("t5_done_exp_vld", 32'(vld1), 32'd0);
        done = 1'b0; req = 16'h0;
        tick();

        // Enable gates new grants only; 1-cycle latency
        en = 1'b0; req = 16'h8000;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_off", 32'(vld0), 32'd0);
        end
        en = 1'b1;
        tick();
        check("t6_vld", 32'(vld0), 32'd1);
        check("t6_idx", 32'(idx0), 32'd15);
        en = 1'b0;
        tick();
        check("t6_persist", 32'(vld0), 32'd1);
        tick();
        check("t6_persist2", 32'(vld0), 32'd1);
        req = 16'h0;
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) req = 16'($urandom & $urandom);
            done = ($urandom_range(0, 4) == 0);
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
